// File: rtl/rx_word_aligner_if.sv
// Receive aligner bus: raw 10-bit words in, aligned symbols and lock status out.
// master drives raw words and loss_clear; slave is the aligner.
interface rx_word_aligner_if;
    logic [9:0] data_rx;
    logic       loss_clear;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_comma;
    logic       locked;
    logic [3:0] offset;
    logic [7:0] loss_count;

    modport master (
        output data_rx, loss_clear,
        input  out_data, out_valid, out_comma, locked, offset, loss_count
    );

    modport slave (
        input  data_rx, loss_clear,
        output out_data, out_valid, out_comma, locked, offset, loss_count
    );
endinterface

// File: rtl/rx_word_aligner.sv
// Finds K28.5 at any of 10 bit offsets, qualifies lock, emits bit-aligned 10-bit symbols.
// Latency: one cycle from the {prev, data_rx} window to out_data/out_comma/out_valid.
// No backpressure: one word per clock in and out; out_valid marks symbols produced while locked.
module rx_word_aligner #(
    parameter int LOCK_COUNT     = 4,
    parameter int LOSS_COUNT     = 4,
    parameter int SEARCH_TIMEOUT = 1023
) (
    input logic              clock,
    input logic              reset,
    rx_word_aligner_if.slave rx
);
    localparam logic [9:0]  K28_5_NEG = 10'b0011111010;
    localparam logic [9:0]  K28_5_POS = 10'b1100000101;
    localparam logic [4:0]  LOCK_N    = 5'(LOCK_COUNT);
    localparam logic [4:0]  LOSS_N    = 5'(LOSS_COUNT);
    localparam logic [10:0] TMO_N     = 11'(SEARCH_TIMEOUT);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state;
    logic [9:0]  prev;
    logic [3:0]  cand;
    logic [3:0]  cnt;
    logic [3:0]  err;
    logic [9:0]  tmo;
    logic [9:0]  out_data_q;
    logic        out_comma_q;
    logic        locked_q;
    logic [7:0]  loss_count_q;

    logic [19:0] window;
    logic [9:0]  match;
    logic [3:0]  first_off;
    logic [9:0]  sel_word;
    logic        any_match;
    logic        hit;
    logic        miss;
    logic        enter_lock;
    logic        drop_lock;
    logic        timeout;
    logic        lock_next;

    assign window = {prev, rx.data_rx};

    // Descending scan so the last assignment to first_off is the lowest matching offset.
    always_comb begin
        match     = '0;
        first_off = '0;
        sel_word  = '0;
        hit       = 1'b0;
        for (int k = 9; k >= 0; k--) begin
            match[k] = (window[19-k -: 10] == K28_5_NEG) || (window[19-k -: 10] == K28_5_POS);
            if (match[k]) begin
                first_off = 4'(k);
            end
            if (cand == 4'(k)) begin
                sel_word = window[19-k -: 10];
                hit      = match[k];
            end
        end
    end

    assign any_match = |match;
    assign miss      = any_match && !hit;

    always_comb begin
        enter_lock = 1'b0;
        drop_lock  = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_SEARCH: enter_lock = any_match && (LOCK_N == 5'd1);
            ST_VERIFY: begin
                enter_lock = hit && (({1'b0, cnt} + 5'd1) == LOCK_N);
                timeout    = !any_match && (({1'b0, tmo} + 11'd1) >= TMO_N);
            end
            ST_LOCKED: drop_lock = miss && (({1'b0, err} + 5'd1) == LOSS_N);
            default: ;
        endcase
        lock_next = enter_lock || ((state == ST_LOCKED) && !drop_lock);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_SEARCH;
            prev         <= '0;
            cand         <= '0;
            cnt          <= '0;
            err          <= '0;
            tmo          <= '0;
            out_data_q   <= '0;
            out_comma_q  <= 1'b0;
            locked_q     <= 1'b0;
            loss_count_q <= '0;
        end else begin
            prev        <= rx.data_rx;
            out_data_q  <= sel_word;
            // Comma flag follows the lock status of the symbol it travels with.
            out_comma_q <= lock_next && hit;
            locked_q    <= lock_next;

            // A loss coinciding with a clear still counts as one event.
            if (rx.loss_clear) begin
                loss_count_q <= drop_lock ? 8'd1 : 8'd0;
            end else if (drop_lock && (loss_count_q != 8'hFF)) begin
                loss_count_q <= loss_count_q + 8'd1;
            end

            case (state)
                ST_SEARCH: begin
                    if (any_match) begin
                        cand  <= first_off;
                        cnt   <= 4'd1;
                        tmo   <= '0;
                        err   <= '0;
                        state <= enter_lock ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (hit) begin
                        cnt <= cnt + 4'd1;
                        tmo <= '0;
                        if (enter_lock) begin
                            state <= ST_LOCKED;
                            err   <= '0;
                        end
                    end else if (miss) begin
                        cand <= first_off;
                        cnt  <= 4'd1;
                        tmo  <= '0;
                    end else begin
                        tmo <= tmo + 10'd1;
                        if (timeout) begin
                            state <= ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (hit) begin
                        err <= '0;
                    end else if (miss) begin
                        err <= err + 4'd1;
                        if (drop_lock) begin
                            state <= ST_SEARCH;
                        end
                    end
                end
                default: state <= ST_SEARCH;
            endcase
        end
    end

    assign rx.out_data   = out_data_q;
    assign rx.out_comma  = out_comma_q;
    assign rx.out_valid  = locked_q;
    assign rx.locked     = locked_q;
    assign rx.offset     = cand;
    assign rx.loss_count = loss_count_q;
endmodule

// File: tb/tb_rx_word_aligner.sv
// Directed bench: serial bit stream sliced into 10-bit words, expected symbols scoreboarded by due cycle.
module tb_rx_word_aligner;
    logic clock = 1'b0;
    logic reset = 1'b1;

    rx_word_aligner_if bus();

    rx_word_aligner #(
        .LOCK_COUNT(4),
        .LOSS_COUNT(4),
        .SEARCH_TIMEOUT(1023)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx(bus)
    );

    always #5 clock = ~clock;

    localparam logic [9:0] KN = 10'b0011111010;
    localparam logic [9:0] KP = 10'b1100000101;

    logic [9:0] dtab [7] = '{10'b1010101010, 10'b0101010101, 10'b1001101001, 10'b0110010110,
                             10'b1100110011, 10'b0011001100, 10'b1010011001};

    typedef struct {logic [9:0] sym; logic comma; int widx;} pend_t;
    typedef struct {logic [9:0] sym; logic comma; int due;} exp_t;

    bit    sbits[$];
    pend_t pend[$];
    exp_t  sb[$];
    int    ccyc[$];
    int    tot_bits = 0;
    int    drv_words = 0;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    rise_cyc = -1;
    int    fall_cyc = -1;
    bit    sb_en = 1'b0;
    bit    clr_arm = 1'b0;
    bit    clr_now = 1'b0;
    logic  last_locked = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [9:0] w;
        pend_t      p;
        @(posedge clock);
        #1;
        w = '0;
        for (int i = 9; i >= 0; i--) begin
            if (sbits.size() > 0) w[i] = sbits.pop_front();
            else                  w[i] = 1'(i & 1);
        end
        bus.data_rx = w;
        while (pend.size() > 0 && pend[0].widx == drv_words) begin
            p = pend.pop_front();
            sb.push_back('{p.sym, p.comma, cyc + 2});
            if (p.comma) ccyc.push_back(cyc);
        end
        drv_words++;
        bus.loss_clear = clr_now || (clr_arm && ccyc.size() >= 4 && cyc == ccyc[3] + 1);
    endtask

    task automatic sym(input logic [9:0] s, input bit c);
        pend.push_back('{s, c, tot_bits / 10});
        for (int i = 9; i >= 0; i--) sbits.push_back(s[i]);
        tot_bits += 10;
        step();
    endtask

    task automatic slip(input int n);
        for (int i = 0; i < n; i++) sbits.push_back(bit'(i % 2 == 0));
        tot_bits += n;
    endtask

    task automatic frames(input int n, input bit alt);
        for (int f = 0; f < n; f++) begin
            sym((alt && f[0]) ? KP : KN, 1'b1);
            for (int j = 0; j < 7; j++) sym(dtab[j], 1'b0);
        end
    endtask

    task automatic flush();
        sbits.delete();
        pend.delete();
        sb.delete();
        ccyc.delete();
        tot_bits  = 0;
        drv_words = 0;
        rise_cyc  = -1;
        fall_cyc  = -1;
    endtask

    // Asserted mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        #3;
        reset       = 1'b1;
        bus.data_rx = 10'b1010101010;
        #1;
        chk({tag, "_locked"},     bus.locked, 0);
        chk({tag, "_out_valid"},  bus.out_valid, 0);
        chk({tag, "_out_comma"},  bus.out_comma, 0);
        chk({tag, "_offset"},     bus.offset, 0);
        chk({tag, "_loss_count"}, bus.loss_count, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        flush();
    endtask

    always @(negedge clock) begin : mon
        bit has;
        if (reset) begin
            last_locked = 1'b0;
        end else begin
            if (bus.locked && !last_locked && rise_cyc < 0) rise_cyc = cyc;
            if (!bus.locked && last_locked) fall_cyc = cyc;
            while (sb.size() > 0 && sb[0].due < cyc) sb.delete(0);
            if (bus.out_valid) begin
                if (sb_en) begin
                    has = (sb.size() > 0) && (sb[0].due == cyc);
                    chk("symbol_due", 32'(has), 1);
                    if (has) begin
                        chk("out_data",  bus.out_data,  sb[0].sym);
                        chk("out_comma", bus.out_comma, sb[0].comma);
                        sb.delete(0);
                    end
                end
            end else begin
                chk("comma_while_invalid", bus.out_comma, 0);
            end
            last_locked = bus.locked;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_rx    = 10'b1010101010;
        bus.loss_clear = 1'b0;
        reset          = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("reset_locked",     bus.locked, 0);
        chk("reset_out_valid",  bus.out_valid, 0);
        chk("reset_out_comma",  bus.out_comma, 0);
        chk("reset_out_data",   bus.out_data, 0);
        chk("reset_offset",     bus.offset, 0);
        chk("reset_loss_count", bus.loss_count, 0);
        reset = 1'b0;
        flush();

        // Aligned stream, RD- commas only.
        sb_en = 1'b1;
        frames(6, 1'b0);
        chk("p1_lock_cycle", rise_cyc, ccyc[3] + 2);
        chk("p1_offset", bus.offset, 0);
        chk("p1_locked", bus.locked, 1);
        chk("p1_valid_eq_locked", bus.out_valid, bus.locked);

        // Same stream delayed by 3 bits, alternating disparity.
        do_reset("rst_a");
        slip(3);
        frames(6, 1'b1);
        chk("p2_lock_cycle", rise_cyc, ccyc[3] + 2);
        chk("p2_offset", bus.offset, 3);
        chk("p2_locked", bus.locked, 1);

        // Stream moves from offset 3 to 6 while locked.
        sb_en = 1'b0;
        ccyc.delete();
        rise_cyc = -1;
        fall_cyc = -1;
        slip(3);
        frames(8, 1'b1);
        chk("p3_loss_cycle", fall_cyc, ccyc[3] + 2);
        chk("p3_relock_cycle", rise_cyc, ccyc[7] + 2);
        chk("p3_loss_count", bus.loss_count, 1);
        chk("p3_offset", bus.offset, 6);
        sb_en = 1'b1;
        frames(2, 1'b1);

        // Plain clear.
        clr_now = 1'b1;
        frames(1, 1'b1);
        clr_now = 1'b0;
        sym(dtab[0], 1'b0);
        chk("clear_loss_count", bus.loss_count, 0);

        // Offset 6 -> 9, loss without clear.
        sb_en = 1'b0;
        ccyc.delete();
        rise_cyc = -1;
        fall_cyc = -1;
        slip(3);
        frames(8, 1'b1);
        chk("p4_loss_count", bus.loss_count, 1);
        chk("p4_relock_cycle", rise_cyc, ccyc[7] + 2);
        chk("p4_offset", bus.offset, 9);
        sb_en = 1'b1;
        frames(1, 1'b1);

        // Offset 9 -> 2 with loss_clear landing on the loss edge.
        sb_en = 1'b0;
        ccyc.delete();
        rise_cyc = -1;
        fall_cyc = -1;
        clr_arm  = 1'b1;
        slip(3);
        frames(8, 1'b1);
        clr_arm = 1'b0;
        chk("p5_coincident_loss_count", bus.loss_count, 1);
        chk("p5_loss_cycle", fall_cyc, ccyc[3] + 2);
        chk("p5_offset", bus.offset, 2);
        chk("p5_locked", bus.locked, 1);
        sb_en = 1'b1;
        frames(1, 1'b1);

        // Async reset while locked at offset 2 with a nonzero loss_count.
        do_reset("rst_locked");

        // Interrupted verify: 2 commas at offset 5, then commas at offset 2.
        slip(5);
        frames(2, 1'b0);
        chk("p6_cand5_offset", bus.offset, 5);
        chk("p6_cand5_locked", bus.locked, 0);
        slip(7);
        frames(1, 1'b0);
        chk("p6_cand2_offset", bus.offset, 2);
        chk("p6_cand2_locked", bus.locked, 0);
        frames(3, 1'b0);
        chk("p6_lock_cycle", rise_cyc, ccyc[5] + 2);
        chk("p6_offset", bus.offset, 2);
        chk("p6_locked", bus.locked, 1);

        // VERIFY timeout: one comma then 1023 comma-free words.
        do_reset("rst_b");
        sym(KN, 1'b1);
        for (int i = 0; i < 1023; i++) sym(dtab[i % 7], 1'b0);
        chk("p7_no_lock_yet", bus.locked, 0);
        chk("p7_no_rise", rise_cyc, -1);
        frames(4, 1'b0);
        chk("p7_lock_cycle", rise_cyc, ccyc[4] + 2);
        chk("p7_loss_count", bus.loss_count, 0);

        // One word short of the timeout: the first comma still counts.
        do_reset("rst_c");
        sym(KN, 1'b1);
        for (int i = 0; i < 1022; i++) sym(dtab[i % 7], 1'b0);
        frames(4, 1'b0);
        chk("p8_lock_cycle", rise_cyc, ccyc[3] + 2);
        chk("p8_locked", bus.locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
